// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory-request arbiter: request kinds,
// requester IDs, FSM states and default bus widths.
package mem_arbiter_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_LINE_W = 128;

   typedef enum logic [2:0] {
      KIND_NONE         = 3'd0,
      KIND_READ_ICACHE  = 3'd1,
      KIND_READ_DCACHE  = 3'd2,
      KIND_WRITE_DCACHE = 3'd3,
      KIND_READ_IO      = 3'd4,
      KIND_WRITE_IO     = 3'd5
   } mem_kind_e;

   typedef enum logic [1:0] {
      REQ_NONE   = 2'd0,
      REQ_ICACHE = 2'd1,
      REQ_DCACHE = 2'd2,
      REQ_IO     = 2'd3
   } req_id_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Memory-controller request channel: arbiter is master, controller is slave.
interface mem_arbiter_if
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int LINE_W = DEF_LINE_W
) ();

   logic              mem_valid;
   logic [2:0]        mem_kind;
   logic [ADDR_W-1:0] mem_addr;
   logic [LINE_W-1:0] mem_wdata;
   logic              mem_accept;
   logic              mem_done;
   logic [LINE_W-1:0] mem_rdata;

   modport master (
      output mem_valid, mem_kind, mem_addr, mem_wdata,
      input  mem_accept, mem_done, mem_rdata
   );

   modport slave (
      input  mem_valid, mem_kind, mem_addr, mem_wdata,
      output mem_accept, mem_done, mem_rdata
   );

endinterface

// File: rtl/mem_arbiter_pick.sv
// Combinational winner selection: io has priority until its streak limit
// is reached while a cache waits; caches round-robin on last_cache.
module mem_arb_pick
   import mem_arbiter_pkg::*;
#(
   parameter int IO_STREAK_MAX = 4,
   parameter int STREAK_W      = 3
) (
   input  logic                icache_valid,
   input  logic                dcache_valid,
   input  logic                io_valid,
   input  req_id_e             excluded,
   input  req_id_e             last_cache,
   input  logic [STREAK_W-1:0] io_streak,
   output req_id_e             winner
);

   logic i_ok, d_ok, io_ok;

   // Mask the excluded requester, then apply the priority rules.
   always_comb begin
      i_ok   = icache_valid && (excluded != REQ_ICACHE);
      d_ok   = dcache_valid && (excluded != REQ_DCACHE);
      io_ok  = io_valid     && (excluded != REQ_IO);
      winner = REQ_NONE;
      if (io_ok && ((io_streak < STREAK_W'(IO_STREAK_MAX)) || !(i_ok || d_ok)))
         winner = REQ_IO;
      else if (i_ok && d_ok)
         winner = (last_cache == REQ_ICACHE) ? REQ_DCACHE : REQ_ICACHE;
      else if (i_ok)
         winner = REQ_ICACHE;
      else if (d_ok)
         winner = REQ_DCACHE;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Front-end scheduler sharing one memory-request channel between icache,
// dcache and io: arbitrate, issue, wait for completion, pulse ready.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W        = DEF_ADDR_W,
   parameter int LINE_W        = DEF_LINE_W,
   parameter int IO_STREAK_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              icache_valid,
   input  logic [ADDR_W-1:0] icache_addr,
   output logic              icache_ready,
   output logic [LINE_W-1:0] icache_data,
   input  logic              dcache_valid,
   input  logic              dcache_rw,
   input  logic [ADDR_W-1:0] dcache_addr,
   input  logic [LINE_W-1:0] dcache_wdata,
   output logic              dcache_ready,
   output logic [LINE_W-1:0] dcache_rdata,
   input  logic              io_valid,
   input  logic              io_rw,
   input  logic [ADDR_W-1:0] io_addr,
   input  logic [7:0]        io_wdata,
   output logic              io_ready,
   output logic [7:0]        io_rdata,
   mem_arbiter_if.master     mem,
   output logic              busy
);

   localparam int STREAK_W = $clog2(IO_STREAK_MAX + 1);
   localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(15);

   state_e              state_q, state_d;
   req_id_e             last_cache_q, excluded_q, owner_q, winner;
   logic [STREAK_W-1:0] io_streak_q;
   logic                grant, capture;

   mem_arb_pick #(
      .IO_STREAK_MAX (IO_STREAK_MAX),
      .STREAK_W      (STREAK_W)
   ) u_pick (
      .icache_valid (icache_valid),
      .dcache_valid (dcache_valid),
      .io_valid     (io_valid),
      .excluded     (excluded_q),
      .last_cache   (last_cache_q),
      .io_streak    (io_streak_q),
      .winner       (winner)
   );

   // Next-state and per-cycle strobes for grant and response capture.
   always_comb begin
      state_d = state_q;
      grant   = 1'b0;
      capture = 1'b0;
      case (state_q)
         ST_IDLE: if (winner != REQ_NONE) begin
            state_d = ST_ISSUE;
            grant   = 1'b1;
         end
         ST_ISSUE: if (mem.mem_accept) begin
            state_d = mem.mem_done ? ST_RESP : ST_WAIT;
            capture = mem.mem_done;
         end
         ST_WAIT: if (mem.mem_done) begin
            state_d = ST_RESP;
            capture = 1'b1;
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)     state_q <= ST_IDLE;
      else if (rdy) state_q <= state_d;
   end

   // Fairness bookkeeping: owner, exclusion window, streak and round-robin.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_cache_q <= REQ_DCACHE;
         excluded_q   <= REQ_NONE;
         owner_q      <= REQ_NONE;
         io_streak_q  <= '0;
      end else if (rdy) begin
         if (state_q == ST_IDLE) excluded_q <= REQ_NONE;
         if (state_q == ST_RESP) excluded_q <= owner_q;
         if (grant) begin
            owner_q <= winner;
            if (winner == REQ_IO) begin
               if (io_streak_q != STREAK_W'(IO_STREAK_MAX))
                  io_streak_q <= io_streak_q + 1'b1;
            end else begin
               io_streak_q  <= '0;
               last_cache_q <= winner;
            end
         end
      end
   end

   // Downstream request registers, loaded on grant, held until accept.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem.mem_valid <= 1'b0;
         mem.mem_kind  <= KIND_NONE;
         mem.mem_addr  <= '0;
         mem.mem_wdata <= '0;
      end else if (rdy) begin
         if (grant) begin
            mem.mem_valid <= 1'b1;
            case (winner)
               REQ_ICACHE: begin
                  mem.mem_kind  <= KIND_READ_ICACHE;
                  mem.mem_addr  <= icache_addr & LINE_MASK;
                  mem.mem_wdata <= '0;
               end
               REQ_DCACHE: begin
                  mem.mem_kind  <= dcache_rw ? KIND_WRITE_DCACHE : KIND_READ_DCACHE;
                  mem.mem_addr  <= dcache_addr & LINE_MASK;
                  mem.mem_wdata <= dcache_rw ? dcache_wdata : '0;
               end
               REQ_IO: begin
                  mem.mem_kind  <= io_rw ? KIND_WRITE_IO : KIND_READ_IO;
                  mem.mem_addr  <= io_addr;
                  mem.mem_wdata <= {{(LINE_W-8){1'b0}}, io_wdata};
               end
               default: ;
            endcase
         end else if ((state_q == ST_ISSUE) && mem.mem_accept) begin
            mem.mem_valid <= 1'b0;
         end
      end
   end

   // Response routing: one-cycle ready to the owner, read data captured.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         icache_ready <= 1'b0;
         dcache_ready <= 1'b0;
         io_ready     <= 1'b0;
         icache_data  <= '0;
         dcache_rdata <= '0;
         io_rdata     <= '0;
      end else if (rdy) begin
         icache_ready <= capture && (owner_q == REQ_ICACHE);
         dcache_ready <= capture && (owner_q == REQ_DCACHE);
         io_ready     <= capture && (owner_q == REQ_IO);
         if (capture) begin
            case (mem.mem_kind)
               KIND_READ_ICACHE: icache_data  <= mem.mem_rdata;
               KIND_READ_DCACHE: dcache_rdata <= mem.mem_rdata;
               KIND_READ_IO:     io_rdata     <= mem.mem_rdata[7:0];
               default: ;
            endcase
         end
      end
   end

   assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the bench plays the memory controller
// and the three requesters with hand-computed expectations.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   logic         clk, rst, rdy;
   logic         icache_valid, icache_ready;
   logic [31:0]  icache_addr;
   logic [127:0] icache_data;
   logic         dcache_valid, dcache_rw, dcache_ready;
   logic [31:0]  dcache_addr;
   logic [127:0] dcache_wdata, dcache_rdata;
   logic         io_valid, io_rw, io_ready;
   logic [31:0]  io_addr;
   logic [7:0]   io_wdata, io_rdata;
   logic         busy;

   int n_vec = 0;
   int n_err = 0;

   logic [127:0] exp_i, exp_d, rd;
   logic [7:0]   exp_io;

   localparam logic [127:0] WLINE = 128'h00112233445566778899AABBCCDDEEFF;

   mem_arbiter_if #(.ADDR_W(32), .LINE_W(128)) mem_bus ();

   mem_arbiter #(.ADDR_W(32), .LINE_W(128), .IO_STREAK_MAX(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .rdy          (rdy),
      .icache_valid (icache_valid),
      .icache_addr  (icache_addr),
      .icache_ready (icache_ready),
      .icache_data  (icache_data),
      .dcache_valid (dcache_valid),
      .dcache_rw    (dcache_rw),
      .dcache_addr  (dcache_addr),
      .dcache_wdata (dcache_wdata),
      .dcache_ready (dcache_ready),
      .dcache_rdata (dcache_rdata),
      .io_valid     (io_valid),
      .io_rw        (io_rw),
      .io_addr      (io_addr),
      .io_wdata     (io_wdata),
      .io_ready     (io_ready),
      .io_rdata     (io_rdata),
      .mem          (mem_bus),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Accept the pending request; done either with accept or one cycle later.
   // Returns positioned in the RESP cycle.
   task automatic serve(input logic [127:0] rdata, input bit same);
      mem_bus.mem_accept = 1'b1;
      mem_bus.mem_done   = same;
      mem_bus.mem_rdata  = rdata;
      step();
      mem_bus.mem_accept = 1'b0;
      mem_bus.mem_done   = 1'b0;
      if (!same) begin
         chk("valid_drop_on_accept", mem_bus.mem_valid, 1'b0);
         chk("busy_in_wait", busy, 1'b1);
         mem_bus.mem_done = 1'b1;
         step();
         mem_bus.mem_done = 1'b0;
      end
   endtask

   task automatic chk_grant(input string tag, input logic [2:0] kind, input logic [31:0] addr);
      chk({tag, "_valid"}, mem_bus.mem_valid, 1'b1);
      chk({tag, "_kind"},  mem_bus.mem_kind, kind);
      chk({tag, "_addr"},  mem_bus.mem_addr, addr);
   endtask

   initial begin
      rst = 1'b0; rdy = 1'b1;
      icache_valid = 0; icache_addr = '0;
      dcache_valid = 0; dcache_rw = 0; dcache_addr = '0; dcache_wdata = '0;
      io_valid = 0; io_rw = 0; io_addr = '0; io_wdata = '0;
      mem_bus.mem_accept = 0; mem_bus.mem_done = 0; mem_bus.mem_rdata = '0;
      exp_i = '0; exp_d = '0; exp_io = '0;
      step(); step();

      // Reset state
      chk("rst_valid", mem_bus.mem_valid, 0);
      chk("rst_kind",  mem_bus.mem_kind, 0);
      chk("rst_addr",  mem_bus.mem_addr, 0);
      chk("rst_wdata", mem_bus.mem_wdata, 0);
      chk("rst_busy",  busy, 0);
      chk("rst_ready", {icache_ready, dcache_ready, io_ready}, 0);
      chk("rst_data",  icache_data | dcache_rdata | 128'(io_rdata), 0);
      rst = 1'b1;

      // icache read, then reset mid-ISSUE
      icache_valid = 1; icache_addr = 32'h1234;
      step();
      chk_grant("ic_first", KIND_READ_ICACHE, 32'h1230);
      chk("ic_busy", busy, 1);
      #2 rst = 1'b0;
      #1;
      chk("midrst_valid", mem_bus.mem_valid, 0);
      chk("midrst_busy",  busy, 0);
      chk("midrst_kind",  mem_bus.mem_kind, 0);
      chk("midrst_addr",  mem_bus.mem_addr, 0);
      rst = 1'b1;
      step();
      chk_grant("ic_after_rst", KIND_READ_ICACHE, 32'h1230);
      serve({4{32'hA5A5A5A5}}, 1'b0);
      exp_i = {4{32'hA5A5A5A5}};
      chk("ic_ready", icache_ready, 1);
      chk("ic_data",  icache_data, exp_i);
      // stale valid held across ready: no regrant in the excluded cycle
      step();
      chk("ic_ready_pulse", icache_ready, 0);
      chk("ic_data_hold",   icache_data, exp_i);
      chk("ic_resp_idle",   busy, 0);
      step();
      chk("ic_excluded", mem_bus.mem_valid, 0);
      icache_valid = 0;
      step();

      // mem_done in IDLE is ignored
      mem_bus.mem_done = 1; mem_bus.mem_rdata = '1;
      step();
      mem_bus.mem_done = 0;
      chk("idle_done_ready", {icache_ready, dcache_ready, io_ready}, 0);
      chk("idle_done_data",  icache_data, exp_i);
      chk("idle_done_busy",  busy, 0);

      // icache/dcache alternation from fresh reset (icache wins first tie)
      rst = 1'b0; #1; rst = 1'b1;
      exp_i = '0; exp_d = '0; exp_io = '0;
      icache_valid = 1; icache_addr = 32'h4000;
      dcache_valid = 1; dcache_rw = 0; dcache_addr = 32'h5004;
      for (int i = 0; i < 4; i++) begin
         step();
         rd = {4{32'hC0DE0000 + 32'(i)}};
         if (i % 2 == 0) begin
            chk_grant("alt_ic", KIND_READ_ICACHE, 32'h4000);
            serve(rd, i[0]);
            exp_i = rd;
            chk("alt_ic_ready", {icache_ready, dcache_ready}, 2'b10);
            chk("alt_ic_data",  icache_data, exp_i);
         end else begin
            chk_grant("alt_dc", KIND_READ_DCACHE, 32'h5000);
            serve(rd, i[0]);
            exp_d = rd;
            chk("alt_dc_ready", {icache_ready, dcache_ready}, 2'b01);
            chk("alt_dc_data",  dcache_rdata, exp_d);
         end
         if (i == 3) begin
            icache_valid = 0; dcache_valid = 0;
         end
         step();
         chk("alt_resp_idle", busy, 0);
      end
      step();

      // io alone four times: streak reaches the limit
      io_valid = 1; io_rw = 0; io_addr = 32'h55;
      for (int i = 0; i < 4; i++) begin
         step();
         chk_grant("io_run", KIND_READ_IO, 32'h55);
         rd = {{15{8'hEE}}, 8'(8'h3C + i)};
         serve(rd, 1'b0);
         exp_io = rd[7:0];
         chk("io_run_ready", io_ready, 1);
         chk("io_run_rdata", io_rdata, exp_io);
         step(); step();
      end
      // streak at limit with a cache waiting: icache wins over io
      icache_valid = 1; icache_addr = 32'h6010;
      step();
      chk_grant("streak_cap_ic", KIND_READ_ICACHE, 32'h6010);
      serve({4{32'h600D600D}}, 1'b1);
      exp_i = {4{32'h600D600D}};
      chk("streak_cap_ic_data", icache_data, exp_i);
      icache_valid = 0;
      step(); step();
      chk_grant("io_after_ic", KIND_READ_IO, 32'h55);
      serve({{15{8'h11}}, 8'h42}, 1'b0);
      exp_io = 8'h42;
      chk("io_after_ic_rdata", io_rdata, exp_io);
      step(); step();
      // streak below limit: io beats a simultaneous icache
      icache_valid = 1;
      step();
      chk_grant("io_below_cap", KIND_READ_IO, 32'h55);
      serve({{15{8'h22}}, 8'h3C}, 1'b0);
      exp_io = 8'h3C;
      chk("io_3c_rdata", io_rdata, exp_io);
      io_valid = 0;
      step(); step();
      chk_grant("ic_after_io", KIND_READ_ICACHE, 32'h6010);
      serve({4{32'h0BADF00D}}, 1'b0);
      exp_i = {4{32'h0BADF00D}};
      chk("ic_after_io_data", icache_data, exp_i);
      icache_valid = 0;
      step(); step();

      // dcache write: payload held until accept, accept+done same cycle
      dcache_valid = 1; dcache_rw = 1; dcache_addr = 32'h2008; dcache_wdata = WLINE;
      step();
      chk_grant("dwr", KIND_WRITE_DCACHE, 32'h2000);
      chk("dwr_wdata", mem_bus.mem_wdata, WLINE);
      step();
      chk_grant("dwr_hold", KIND_WRITE_DCACHE, 32'h2000);
      chk("dwr_hold_wdata", mem_bus.mem_wdata, WLINE);
      serve('1, 1'b1);
      chk("dwr_ready", dcache_ready, 1);
      chk("dwr_rdata_unchanged", dcache_rdata, exp_d);
      // freeze during RESP
      rdy = 0;
      step(); step();
      chk("frz_ready", dcache_ready, 1);
      chk("frz_busy",  busy, 1);
      rdy = 1; dcache_valid = 0;
      step();
      chk("unfrz_ready", dcache_ready, 0);
      chk("unfrz_busy",  busy, 0);
      step();

      // io write: zero-extended payload, ready pulse, data left unchanged
      io_valid = 1; io_rw = 1; io_addr = 32'h77; io_wdata = 8'h5A;
      step();
      chk_grant("iowr", KIND_WRITE_IO, 32'h77);
      chk("iowr_wdata", mem_bus.mem_wdata, 128'h5A);
      serve('1, 1'b0);
      chk("iowr_ready", io_ready, 1);
      chk("iowr_rdata_unchanged", io_rdata, exp_io);
      io_valid = 0;
      step(); step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
